button_event: RTL and testbench



---
 rtl/button_event_pkg.sv | 15 +
 rtl/button_event_tick_gen.sv | 29 ++
 rtl/button_event.sv | 124 ++++++++++++
 tb/tb_button_event.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state encodings and 50 MHz timing defaults for button_event
package button_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  localparam int TICK_N_DEF       = 19;
  localparam int CNT_W_DEF        = 8;
  localparam int LONG_TICKS_DEF   = 48;
  localparam int REPEAT_TICKS_DEF = 10;

endpackage

// File: rtl/button_event_tick_gen.sv
// rtl/button_event_tick_gen.sv - free-running prescaler, tick on the last count of each period
module tick_gen
  import button_event_pkg::*;
#(
  parameter int TICK_N = TICK_N_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [TICK_N-1:0] CNT_MAX = '1;

  logic [TICK_N-1:0] cnt;

  // Wrap to 0 on the tick falls out of the natural overflow at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == CNT_MAX);

endmodule

// File: rtl/button_event.sv
// rtl/button_event.sv - turns a debounced button level into press/release/short/long/repeat pulses
module button_event
  import button_event_pkg::*;
#(
  parameter int TICK_N       = TICK_N_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic db_in,
  input  logic repeat_en,
  output logic press_p,
  output logic release_p,
  output logic short_p,
  output logic long_p,
  output logic repeat_p,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic             db_q;
  logic             rise, fall, tick, run;
  logic             press_nx, release_nx, short_nx, long_nx, repeat_nx;

  assign rise = db_in && !db_q;
  assign fall = !db_in && db_q;
  assign run  = (state == ST_PRESSED) || (state == ST_LONG);

  // Prescaler is held cleared in IDLE, so every press starts a fresh tick phase.
  tick_gen #(
    .TICK_N (TICK_N)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (!run),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    press_nx    = 1'b0;
    release_nx  = 1'b0;
    short_nx    = 1'b0;
    long_nx     = 1'b0;
    repeat_nx   = 1'b0;
    case (state)
      ST_IDLE: begin
        hold_cnt_nx = '0;
        if (rise) begin
          press_nx = 1'b1;
          state_nx = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        // A fall is checked before the tick so release beats a coincident long threshold.
        if (fall) begin
          release_nx = 1'b1;
          short_nx   = 1'b1;
          state_nx   = ST_IDLE;
        end else if (tick) begin
          if (hold_cnt == LONG_LAST) begin
            long_nx     = 1'b1;
            hold_cnt_nx = '0;
            state_nx    = ST_LONG;
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
      end
      ST_LONG: begin
        if (fall) begin
          release_nx = 1'b1;
          state_nx   = ST_IDLE;
        end else if (tick) begin
          // The counter keeps its grid even while repeat_en is low.
          if (hold_cnt == REPEAT_LAST) begin
            hold_cnt_nx = '0;
            repeat_nx   = repeat_en;
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        hold_cnt_nx = '0;
      end
    endcase
  end

  // db_q resets high so a button held through reset needs a release first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      db_q      <= 1'b1;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      short_p   <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
      held      <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_cnt_nx;
      db_q      <= db_in;
      press_p   <= press_nx;
      release_p <= release_nx;
      short_p   <= short_nx;
      long_p    <= long_nx;
      repeat_p  <= repeat_nx;
      held      <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - scoreboard bench for button_event with TICK_N=2, LONG_TICKS=3, REPEAT_TICKS=2
module tb_button_event;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db_in = 1'b0;
  logic repeat_en = 1'b0;
  logic press_p, release_p, short_p, long_p, repeat_p, held;

  button_event #(
    .TICK_N       (2),
    .CNT_W        (8),
    .LONG_TICKS   (3),
    .REPEAT_TICKS (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .db_in     (db_in),
    .repeat_en (repeat_en),
    .press_p   (press_p),
    .release_p (release_p),
    .short_p   (short_p),
    .long_p    (long_p),
    .repeat_p  (repeat_p),
    .held      (held)
  );

  always #5 clk = ~clk;

  // Pulse vector order: {press, release, short, long, repeat}
  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_REP   = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   c0;
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  // Every enabled cycle: pulses must equal the scheduled event or be all zero.
  always @(negedge clk) begin
    logic [4:0] obs;
    logic [4:0] want;
    if (mon_en) begin
      obs  = {press_p, release_p, short_p, long_p, repeat_p};
      want = 5'b00000;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        want = sb[0].ev;
        void'(sb.pop_front());
      end
      total++;
      assert (obs === want) else begin
        bad++;
        $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, obs, want);
      end
    end
  end

  initial begin
    reset = 1'b1;
    db_in = 1'b0;
    repeat_en = 1'b0;
    step(3);
    check("reset_press", press_p, 1'b0);
    check("reset_release", release_p, 1'b0);
    check("reset_short", short_p, 1'b0);
    check("reset_long", long_p, 1'b0);
    check("reset_repeat", repeat_p, 1'b0);
    check("reset_held", held, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Short press: 5 sampled cycles high.
    c0 = cyc;
    db_in = 1'b1;
    expect_ev(c0 + 1, EV_PRESS);
    expect_ev(c0 + 6, EV_REL | EV_SHORT);
    step(1);
    check("short_held_hi", held, 1'b1);
    step(4);
    db_in = 1'b0;
    step(1);
    check("short_held_lo", held, 1'b0);
    step(3);

    // Long hold with repeats.
    repeat_en = 1'b1;
    c0 = cyc;
    t0 = c0 + 1;
    db_in = 1'b1;
    expect_ev(t0, EV_PRESS);
    expect_ev(t0 + 12, EV_LONG);
    expect_ev(t0 + 20, EV_REP);
    expect_ev(t0 + 28, EV_REP);
    expect_ev(t0 + 36, EV_REP);
    expect_ev(t0 + 40, EV_REL);
    step(40);
    check("long_held_hi", held, 1'b1);
    db_in = 1'b0;
    step(4);

    // repeat_en low, re-enabled mid-hold: next repeat on the original grid.
    repeat_en = 1'b0;
    c0 = cyc;
    t0 = c0 + 1;
    db_in = 1'b1;
    expect_ev(t0, EV_PRESS);
    expect_ev(t0 + 12, EV_LONG);
    expect_ev(t0 + 28, EV_REP);
    expect_ev(t0 + 31, EV_REL);
    step(23);
    repeat_en = 1'b1;
    step(8);
    db_in = 1'b0;
    step(4);

    // Fall coincides with the long-threshold tick: short wins.
    c0 = cyc;
    t0 = c0 + 1;
    db_in = 1'b1;
    expect_ev(t0, EV_PRESS);
    expect_ev(t0 + 12, EV_REL | EV_SHORT);
    step(12);
    db_in = 1'b0;
    step(4);

    // Button held across reset is ignored until released and pressed again.
    db_in = 1'b1;
    reset = 1'b1;
    step(2);
    check("rst_hold_press", press_p, 1'b0);
    reset = 1'b0;
    step(6);
    check("rst_hold_held", held, 1'b0);
    db_in = 1'b0;
    step(2);
    c0 = cyc;
    db_in = 1'b1;
    expect_ev(c0 + 1, EV_PRESS);
    step(3);
    db_in = 1'b0;
    expect_ev(c0 + 4, EV_REL | EV_SHORT);
    step(4);

    // Reset in LONG: everything cleared, no release, fresh press still seen.
    c0 = cyc;
    t0 = c0 + 1;
    db_in = 1'b1;
    expect_ev(t0, EV_PRESS);
    expect_ev(t0 + 12, EV_LONG);
    step(15);
    reset = 1'b1;
    step(1);
    check("midrst_held", held, 1'b0);
    check("midrst_release", release_p, 1'b0);
    check("midrst_long", long_p, 1'b0);
    reset = 1'b0;
    step(3);
    db_in = 1'b0;
    step(2);
    c0 = cyc;
    db_in = 1'b1;
    expect_ev(c0 + 1, EV_PRESS);
    step(2);
    db_in = 1'b0;
    expect_ev(c0 + 3, EV_REL | EV_SHORT);
    step(4);

    mon_en = 1'b0;
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drained observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
